// File: rtl/aq_fadd_norm_shift_pipe.sv
// aq_fadd_norm_shift_pipe
// Two-stage left-normalisation shifter between the mantissa adder and the
// rounding stage of the FADD datapath.
//   Stage 1 picks the shift amount. In mode 0 this is the leading-zero count,
//   clamped to max_cnt. In mode 1 it is shift_cnt, used directly.
//   Stage 2 applies the barrel shift and registers the result and its flags.
// Ports:
//   forever_cpuclk, cpurst_b : clock (rising edge), synchronous active-low reset
//   flush                    : kills every in-flight entry at the next edge
//   in_vld / in_rdy          : input handshake
//   mode, data_in            : shift mode, mantissa
//   shift_cnt, max_cnt       : direct count (mode 1), clamp limit (mode 0)
//   out_vld / out_rdy        : output handshake
//   data_out, shift_amt      : shifted mantissa, amount applied
//   zero, limited, lost      : result flags
module aq_fadd_norm_shift_pipe #(
   parameter int DATA_WIDTH = 54,
   parameter int CNT_WIDTH  = 6
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  flush,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic                  mode,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [CNT_WIDTH-1:0]  shift_cnt,
   input  logic [CNT_WIDTH-1:0]  max_cnt,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [CNT_WIDTH-1:0]  shift_amt,
   output logic                  zero,
   output logic                  limited,
   output logic                  lost
);

   localparam logic [CNT_WIDTH-1:0] W_CNT = CNT_WIDTH'(DATA_WIDTH);

   // Stage 1 registers
   logic                  s1_vld;
   logic [DATA_WIDTH-1:0] s1_data;
   logic [CNT_WIDTH-1:0]  s1_amt;
   logic                  s1_mode;
   logic                  s1_limited;

   // Stage 2 registers (drive the outputs directly)
   logic                  s2_vld;
   logic [DATA_WIDTH-1:0] s2_data;
   logic [CNT_WIDTH-1:0]  s2_amt;
   logic                  s2_zero;
   logic                  s2_limited;
   logic                  s2_lost;

   logic s2_adv;
   logic s1_adv;

   // A stage may load whenever its successor can take what it holds.
   assign s2_adv = !s2_vld || out_rdy;
   assign s1_adv = !s1_vld || s2_adv;
   assign in_rdy = s1_adv && !flush;

   // Leading-zero count. An all-zero word returns DATA_WIDTH.
   function automatic logic [CNT_WIDTH-1:0] lzc_f(input logic [DATA_WIDTH-1:0] d);
      logic [CNT_WIDTH-1:0] n;
      logic                 found;
      n     = W_CNT;
      found = 1'b0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         if (!found && d[i]) begin
            n     = CNT_WIDTH'(DATA_WIDTH - 1 - i);
            found = 1'b1;
         end
      end
      return n;
   endfunction

   logic [CNT_WIDTH-1:0] st1_lzc;
   logic [CNT_WIDTH-1:0] st1_amt;
   logic                 st1_limited;

   always_comb begin
      st1_lzc     = lzc_f(data_in);
      st1_amt     = '0;
      st1_limited = 1'b0;
      if (mode) begin
         st1_amt = shift_cnt;
      end else if (data_in != '0) begin
         if (st1_lzc > max_cnt) begin
            st1_amt     = max_cnt;
            st1_limited = 1'b1;
         end else begin
            st1_amt = st1_lzc;
         end
      end
   end

   logic [DATA_WIDTH-1:0] st2_data;
   logic [DATA_WIDTH-1:0] st2_top_mask;
   logic                  st2_lost;

   always_comb begin
      st2_data = '0;
      if (s1_amt < W_CNT) begin
         st2_data = s1_data << s1_amt;
      end
      // Covers the top min(amt, DATA_WIDTH) bits. The logical right shift
      // saturates to zero for large amounts, so the mask becomes all ones.
      st2_top_mask = ~({DATA_WIDTH{1'b1}} >> s1_amt);
      st2_lost     = s1_mode && ((s1_data & st2_top_mask) != '0);
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         s1_vld     <= 1'b0;
         s1_data    <= '0;
         s1_amt     <= '0;
         s1_mode    <= 1'b0;
         s1_limited <= 1'b0;
         s2_vld     <= 1'b0;
         s2_data    <= '0;
         s2_amt     <= '0;
         s2_zero    <= 1'b0;
         s2_limited <= 1'b0;
         s2_lost    <= 1'b0;
      end else if (flush) begin
         s1_vld <= 1'b0;
         s2_vld <= 1'b0;
      end else begin
         if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
               s2_data    <= st2_data;
               s2_amt     <= s1_amt;
               s2_zero    <= (st2_data == '0);
               s2_limited <= s1_limited;
               s2_lost    <= st2_lost;
            end
         end
         if (s1_adv) begin
            s1_vld <= in_vld;
            if (in_vld) begin
               s1_data    <= data_in;
               s1_amt     <= st1_amt;
               s1_mode    <= mode;
               s1_limited <= st1_limited;
            end
         end
      end
   end

   assign out_vld   = s2_vld;
   assign data_out  = s2_data;
   assign shift_amt = s2_amt;
   assign zero      = s2_zero;
   assign limited   = s2_limited;
   assign lost      = s2_lost;

endmodule

// File: tb/tb_aq_fadd_norm_shift_pipe.sv
// Self-checking bench for aq_fadd_norm_shift_pipe (DATA_WIDTH=54, CNT_WIDTH=6).
module tb_aq_fadd_norm_shift_pipe;

   localparam int W  = 54;
   localparam int CW = 6;

   logic          clk;
   logic          rst_b;
   logic          flush;
   logic          in_vld;
   logic          in_rdy;
   logic          mode;
   logic [W-1:0]  data_in;
   logic [CW-1:0] shift_cnt;
   logic [CW-1:0] max_cnt;
   logic          out_vld;
   logic          out_rdy;
   logic [W-1:0]  data_out;
   logic [CW-1:0] shift_amt;
   logic          zero;
   logic          limited;
   logic          lost;

   int checks   = 0;
   int failures = 0;

   aq_fadd_norm_shift_pipe #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .forever_cpuclk (clk),
      .cpurst_b       (rst_b),
      .flush          (flush),
      .in_vld         (in_vld),
      .in_rdy         (in_rdy),
      .mode           (mode),
      .data_in        (data_in),
      .shift_cnt      (shift_cnt),
      .max_cnt        (max_cnt),
      .out_vld        (out_vld),
      .out_rdy        (out_rdy),
      .data_out       (data_out),
      .shift_amt      (shift_amt),
      .zero           (zero),
      .limited        (limited),
      .lost           (lost)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          m;
      logic [W-1:0]  d;
      logic [CW-1:0] sc;
      logic [CW-1:0] mc;
      logic [W-1:0]  ed;
      logic [CW-1:0] ea;
      logic          ez;
      logic          el;
      logic          elost;
   } vec_t;

   vec_t vecs [10];

   // Packed result layout: {data_out, shift_amt, zero, limited, lost}
   function automatic logic [62:0] dut_res();
      return {data_out, shift_amt, zero, limited, lost};
   endfunction

   // Reference: counts leading zeros by normalising a copy, then applies the
   // clamp / direct-count rules with plain arithmetic.
   function automatic logic [62:0] model(input logic m, input logic [W-1:0] d,
                                         input logic [CW-1:0] sc, input logic [CW-1:0] mc);
      int           n;
      int           amt;
      logic [W-1:0] x;
      logic [W-1:0] r;
      logic         lim;
      logic         lst;
      n = 0;
      x = d;
      while (n < W && x[W-1] == 1'b0) begin
         x = x << 1;
         n++;
      end
      lim = 1'b0;
      lst = 1'b0;
      if (m) amt = int'(sc);
      else if (d == '0) amt = 0;
      else begin
         amt = (n > int'(mc)) ? int'(mc) : n;
         lim = (n > int'(mc));
      end
      r = (amt >= W) ? '0 : (d << amt);
      if (m && amt > 0) lst = (amt >= W) ? (d != '0) : ((d >> (W - amt)) != '0);
      return {r, CW'(amt), (r == '0), lim, lst};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge; outputs are then
   // stable and in_rdy has settled for these inputs.
   task automatic cyc(input logic rst, input logic v, input logic m, input logic [W-1:0] d,
                      input logic [CW-1:0] sc, input logic [CW-1:0] mc,
                      input logic ordy, input logic fl);
      @(negedge clk);
      rst_b     = rst;
      in_vld    = v;
      mode      = m;
      data_in   = d;
      shift_cnt = sc;
      max_cnt   = mc;
      out_rdy   = ordy;
      flush     = fl;
      #1;
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, ordy, 1'b0);
   endtask

   // Single entry through an empty pipe, with exact latency checks.
   task automatic run_vec(input vec_t v, input string name);
      cyc(1'b1, 1'b1, v.m, v.d, v.sc, v.mc, 1'b1, 1'b0);
      chk({name, "_in_rdy"}, 64'(in_rdy), 64'd1);
      idle(1'b1);
      chk({name, "_vld_early"}, 64'(out_vld), 64'd0);
      idle(1'b1);
      chk({name, "_vld"}, 64'(out_vld), 64'd1);
      chk({name, "_res"}, 64'(dut_res()), 64'({v.ed, v.ea, v.ez, v.el, v.elost}));
   endtask

   logic [62:0] q[$];
   logic [62:0] exp_bp [4];
   logic [W-1:0] bp_d [4];
   logic [63:0] held;
   logic        held_v;

   initial begin
      vecs[0] = '{1'b0, 54'h1, 6'd0, 6'd63, 54'h20_0000_0000_0000, 6'd53, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 54'h1, 6'd0, 6'd10, 54'h400, 6'd10, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{1'b0, 54'h0, 6'd0, 6'd10, 54'h0, 6'd0, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{1'b1, 54'h3C_0000_0000_0001, 6'd4, 6'd0, 54'h10, 6'd4, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{1'b1, 54'h1, 6'd54, 6'd0, 54'h0, 6'd54, 1'b1, 1'b0, 1'b1};
      vecs[5] = '{1'b1, 54'h3C_0000_0000_0001, 6'd0, 6'd0, 54'h3C_0000_0000_0001, 6'd0, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{1'b0, 54'h800_0000_0000, 6'd0, 6'd10, 54'h20_0000_0000_0000, 6'd10, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{1'b0, 54'h20_0000_0000_0000, 6'd0, 6'd0, 54'h20_0000_0000_0000, 6'd0, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{1'b1, 54'h0, 6'd63, 6'd0, 54'h0, 6'd63, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{1'b1, 54'h3F_FFFF_FFFF_FFFF, 6'd1, 6'd0, 54'h3F_FFFF_FFFF_FFFE, 6'd1, 1'b0, 1'b0, 1'b1};

      // Reset state
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
      chk("reset_out_vld", 64'(out_vld), 64'd0);
      chk("reset_outputs", 64'(dut_res()), 64'd0);
      idle(1'b1);

      // Table vectors
      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end
      idle(1'b1);

      // Back-pressure: A..D back to back, out_rdy low for the first 5 cycles
      bp_d[0] = 54'h1;
      bp_d[1] = 54'h3C_0000_0000_0001;
      bp_d[2] = 54'h0_0F00_0000_1234;
      bp_d[3] = 54'h2A_5555_0000_FFFF;
      for (int i = 0; i < 4; i++) exp_bp[i] = model(1'b1, bp_d[i], CW'(i + 3), '0);
      begin
         int p;
         int popn;
         p    = 0;
         popn = 0;
         for (int c = 0; c < 12; c++) begin
            logic v;
            logic ordy;
            v    = (p < 4);
            ordy = (c >= 5);
            cyc(1'b1, v, 1'b1, v ? bp_d[p] : '0, CW'(p + 3), '0, ordy, 1'b0);
            if (c == 1) chk("bp_rdy_second", 64'(in_rdy), 64'd1);
            if (c >= 2 && c <= 4) begin
               chk("bp_rdy_stalled", 64'(in_rdy), 64'd0);
               chk("bp_vld_stalled", 64'(out_vld), 64'd1);
               chk("bp_data_stalled", 64'(dut_res()), 64'(exp_bp[0]));
            end
            if (out_vld && ordy) begin
               if (popn < 4) chk($sformatf("bp_pop%0d", popn), 64'(dut_res()), 64'(exp_bp[popn]));
               else chk("bp_dup_pop", 64'(popn), 64'd3);
               popn++;
            end
            if (v && in_rdy) p++;
         end
         chk("bp_pop_count", 64'(popn), 64'd4);
         chk("bp_accept_count", 64'(p), 64'd4);
      end
      idle(1'b1);

      // Flush with two entries in flight
      cyc(1'b1, 1'b1, 1'b1, 54'h3, 6'd2, '0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 54'h5, 6'd3, '0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 54'h7, 6'd4, '0, 1'b1, 1'b1);
      chk("flush_in_rdy", 64'(in_rdy), 64'd0);
      chk("flush_pre_vld", 64'(out_vld), 64'd1);
      cyc(1'b1, 1'b1, 1'b0, 54'h0_0000_0100_0000, '0, 6'd63, 1'b1, 1'b0);
      chk("flush_post_vld", 64'(out_vld), 64'd0);
      chk("flush_post_rdy", 64'(in_rdy), 64'd1);
      idle(1'b1);
      chk("flush_f_early", 64'(out_vld), 64'd0);
      idle(1'b1);
      chk("flush_f_vld", 64'(out_vld), 64'd1);
      chk("flush_f_res", 64'(dut_res()), 64'(model(1'b0, 54'h0_0000_0100_0000, '0, 6'd63)));
      idle(1'b1);
      chk("flush_no_stale", 64'(out_vld), 64'd0);

      // Reset with both stages valid and out_rdy low
      cyc(1'b1, 1'b1, 1'b1, 54'h1, 6'd5, '0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 54'h3, 6'd6, '0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
      idle(1'b0);
      chk("midrst_out_vld", 64'(out_vld), 64'd0);
      chk("midrst_outputs", 64'(dut_res()), 64'd0);
      run_vec(vecs[1], "midrst_resume");
      idle(1'b1);

      // Randomised traffic against the scoreboard
      held_v = 1'b0;
      held   = '0;
      for (int c = 0; c < 600; c++) begin
         logic          v;
         logic          m;
         logic          ordy;
         logic          fl;
         logic [W-1:0]  d;
         logic [CW-1:0] sc;
         logic [CW-1:0] mc;
         logic [63:0]   r64;
         r64  = {$urandom(), $urandom()};
         d    = W'(r64) >> $urandom_range(0, W);
         v    = ($urandom_range(0, 3) != 0);
         m    = $urandom_range(0, 1) == 1;
         ordy = ($urandom_range(0, 9) < 7);
         fl   = ($urandom_range(0, 39) == 0);
         sc   = CW'($urandom_range(0, 63));
         mc   = CW'($urandom_range(0, 63));
         cyc(1'b1, v, m, d, sc, mc, ordy, fl);
         chk("rand_in_rdy", 64'(in_rdy), 64'(!fl && (q.size() < 2 || ordy)));
         if (held_v) chk("rand_hold", {out_vld, dut_res()}, held);
         if (out_vld) begin
            chk("rand_occupancy", 64'(q.size() > 0), 64'd1);
            if (ordy && q.size() > 0) chk("rand_pop", 64'(dut_res()), 64'(q.pop_front()));
         end
         held_v = out_vld && !ordy && !fl;
         held   = {out_vld, dut_res()};
         if (fl) q.delete();
         else if (v && in_rdy) q.push_back(model(m, d, sc, mc));
      end
      for (int c = 0; c < 6; c++) begin
         idle(1'b1);
         if (out_vld) begin
            chk("drain_occupancy", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) chk("drain_pop", 64'(dut_res()), 64'(q.pop_front()));
         end
      end
      chk("drain_empty", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
